// File: rtl/fetch_sequencer_pkg.sv
// Shared types and helpers for the fetch/sequencing stage.
package fetch_sequencer_pkg;

   // Memory access state machine encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } mem_state_e;

   // Width of the opcode field that sits above the address field in a word
   function automatic int unsigned opcode_width(input int unsigned word_width,
                                                input int unsigned address_width);
      return word_width - address_width;
   endfunction

endpackage

// File: rtl/mem_handshake.sv
// Request/ready handshake FSM towards program memory, with overrun detection.
module mem_handshake
   import fetch_sequencer_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic mem_read,
   input  logic mem_write,
   input  logic mem_ready,
   output logic mem_req,
   output logic mem_we,
   output logic busy,
   output logic overrun_c,
   output logic rd_done_c,
   output logic idle_c
);

   mem_state_e state;
   mem_state_e state_nxt;

   assign idle_c = (state == ST_IDLE);
   assign busy   = mem_req;

   // Next state, overrun and read-completion decode
   always_comb begin
      state_nxt = state;
      overrun_c = 1'b0;
      rd_done_c = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem_read) begin
               state_nxt = ST_READ;
               overrun_c = mem_write;
            end else if (mem_write) begin
               state_nxt = ST_WRITE;
            end
         end
         ST_READ: begin
            overrun_c = mem_read | mem_write;
            if (mem_ready) begin
               state_nxt = ST_IDLE;
               rd_done_c = 1'b1;
            end
         end
         ST_WRITE: begin
            overrun_c = mem_read | mem_write;
            if (mem_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register; request/write-enable registered from the next state so reset drops them at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
      end else begin
         state   <= state_nxt;
         mem_req <= (state_nxt != ST_IDLE);
         mem_we  <= (state_nxt == ST_WRITE);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter, address/data/instruction registers, bus mux and memory access control.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int unsigned WORD_WIDTH    = 8,
   parameter int unsigned ADDRESS_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pc_out,
   input  logic                       pc_load,
   input  logic                       pc_inc,
   input  logic                       ar_load,
   input  logic                       dr_load,
   input  logic                       dr_out,
   input  logic                       ir_load,
   input  logic                       ir_addr_out,
   input  logic                       mem_read,
   input  logic                       mem_write,
   input  logic [WORD_WIDTH-1:0]      bus_in,
   output logic [WORD_WIDTH-1:0]      bus_out,
   output logic                       bus_out_en,
   output logic [ADDRESS_WIDTH-1:0]   mem_addr,
   output logic [WORD_WIDTH-1:0]      mem_wdata,
   output logic                       mem_req,
   output logic                       mem_we,
   input  logic [WORD_WIDTH-1:0]      mem_rdata,
   input  logic                       mem_ready,
   output logic                       busy,
   output logic [opcode_width(WORD_WIDTH, ADDRESS_WIDTH)-1:0] instr,
   output logic [ADDRESS_WIDTH-1:0]   pc,
   output logic                       error
);

   logic [ADDRESS_WIDTH-1:0] ar;
   logic [WORD_WIDTH-1:0]    dr;
   logic [WORD_WIDTH-1:0]    ir;
   logic                     overrun_c;
   logic                     rd_done_c;
   logic                     idle_c;
   logic                     conflict_c;

   mem_handshake u_mem_handshake (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .busy      (busy),
      .overrun_c (overrun_c),
      .rd_done_c (rd_done_c),
      .idle_c    (idle_c)
   );

   assign mem_addr  = ar;
   assign mem_wdata = dr;
   assign instr     = ir[WORD_WIDTH-1:ADDRESS_WIDTH];

   // Two or more simultaneous bus drivers
   assign conflict_c = (pc_out & dr_out) | (pc_out & ir_addr_out) | (dr_out & ir_addr_out);

   // Bus driver mux, priority PC > DR > IR address field; quiet while in reset
   always_comb begin
      bus_out    = '0;
      bus_out_en = 1'b0;
      if (!rst) begin
         bus_out_en = pc_out | dr_out | ir_addr_out;
         if (pc_out) begin
            bus_out = WORD_WIDTH'(pc);
         end else if (dr_out) begin
            bus_out = dr;
         end else if (ir_addr_out) begin
            bus_out = WORD_WIDTH'(ir[ADDRESS_WIDTH-1:0]);
         end
      end
   end

   // Program counter: load beats increment, increment wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= '0;
      end else if (pc_load) begin
         pc <= bus_in[ADDRESS_WIDTH-1:0];
      end else if (pc_inc) begin
         pc <= pc + ADDRESS_WIDTH'(1);
      end
   end

   // Address register, frozen while an access is pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ar <= '0;
      end else if (ar_load && idle_c) begin
         ar <= bus_in[ADDRESS_WIDTH-1:0];
      end
   end

   // Data register: read completion wins over a bus load; bus loads only when idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dr <= '0;
      end else if (rd_done_c) begin
         dr <= mem_rdata;
      end else if (dr_load && idle_c) begin
         dr <= bus_in;
      end
   end

   // Instruction register takes the data register value from before the edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir <= '0;
      end else if (ir_load) begin
         ir <= dr;
      end
   end

   // Sticky error for bus conflicts and request overruns
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         error <= 1'b0;
      end else if (conflict_c || overrun_c) begin
         error <= 1'b1;
      end
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-sequencing and memory-access stage directly upstream of the control unit: holds the program counter, address register, data register and instruction register, and supplies the opcode field that the control unit decodes. It consumes the control unit's one-hot control signals, which the control unit updates on the falling edge, and acts on them at the following rising edge. It drives the internal word bus and runs a request/ready handshake to program memory.

## Interface
- `WORD_WIDTH`, 8, bus and memory word width
- `ADDRESS_WIDTH`, 5, address field and PC width; opcode width = `WORD_WIDTH-ADDRESS_WIDTH`
- `CLK` in 1: single clock; all state updates on rising edge
- `RST` in 1: asynchronous, active-high reset
- `pc_out` in 1: drive PC onto bus
- `pc_load` in 1: load PC from `bus_in[ADDRESS_WIDTH-1:0]`
- `pc_inc` in 1: PC + 1
- `ar_load` in 1: load address register from `bus_in[ADDRESS_WIDTH-1:0]`
- `dr_load` in 1: load data register from `bus_in`
- `dr_out` in 1: drive data register onto bus
- `ir_load` in 1: load IR from data register
- `ir_addr_out` in 1: drive IR address field, zero-extended, onto bus
- `mem_read` / `mem_write` in 1: start memory access at address register
- `bus_in` in `WORD_WIDTH`: bus value from datapath
- `bus_out` out `WORD_WIDTH`: bus value driven by this block
- `bus_out_en` out 1: this block drives the bus
- `mem_addr` out `ADDRESS_WIDTH`: equals address register
- `mem_wdata` out `WORD_WIDTH`: equals data register
- `mem_req` out 1: access pending
- `mem_we` out 1: pending access is a write
- `mem_rdata` in `WORD_WIDTH`: read data, valid with `mem_ready`
- `mem_ready` in 1: completes pending access this cycle
- `busy` out 1: memory state machine not IDLE
- `instr` out `WORD_WIDTH-ADDRESS_WIDTH`: IR opcode field, to control unit
- `pc` out `ADDRESS_WIDTH`: current PC
- `error` out 1: sticky bus-conflict or request-overrun flag

## Operation
- Reset: PC, address register, data register, IR = 0; state IDLE; `mem_req`, `mem_we`, `busy`, `error`, `bus_out_en` = 0; `bus_out` = 0.
- PC: `pc_load` takes priority over `pc_inc`; increment wraps 2^`ADDRESS_WIDTH`-1 → 0.
- Bus drive, combinational, priority `pc_out` > `dr_out` > `ir_addr_out`; `bus_out_en` is the OR of all three. With no driver active, `bus_out` = 0. Two or more drivers active in one cycle sets `error`.
- Data register: a completed read (`mem_ready` in READ) takes priority over `dr_load`.
- `ir_load` copies the data register value held before the edge.
- Memory FSM states IDLE, READ, WRITE:
  - IDLE→READ on `mem_read`; IDLE→WRITE on `mem_write`. Both asserted together: READ is taken and `error` is set.
  - READ/WRITE→IDLE on `mem_ready`; READ also captures `mem_rdata` into the data register.
  - `mem_req` = (state != IDLE); `mem_we` = (state == WRITE); `busy` = `mem_req`.
  - `mem_read`/`mem_write` asserted while not IDLE: ignored, `error` set.
  - `ar_load`/`dr_load` while not IDLE: ignored, so address and write data stay stable through the access.
- `mem_ready` in IDLE: ignored.
- `error` is cleared only by `RST`.
- `RST` mid-access aborts immediately: `mem_req` drops asynchronously.

## Timing
- Control inputs sampled on the rising edge after the control unit's falling-edge update; registers visible the same cycle after the edge.
- Memory access latency ≥1 cycle: the request registers at edge N, and the earliest completion is `mem_ready` high at edge N+1.
- Read data is in the data register after the completing edge; `ir_load` one edge later makes `instr` valid.
- Bus outputs are combinational from registers and control inputs; there is no register on the bus path.

## Structure
- Shared package holds:
  - the memory FSM state enum (IDLE=0, READ=1, WRITE=2, 2-bit)
  - the opcode-field width function
- One natural sub-module, `mem_handshake`: the FSM plus the `mem_req`/`mem_we`/`busy`/overrun logic. The top level holds the registers and the bus mux.

## Test plan
- Reset during a READ (`mem_req`=1, AR=5) → all outputs 0 without waiting for a clock edge, including `mem_req`=0.
- PC=31, `pc_inc` → PC=0; `pc_load` and `pc_inc` with `bus_in`=0x0A → PC=10.
- Read sequence: `ar_load` with `bus_in`=3; then `mem_read`; `mem_ready` held low 2 cycles, then high with `mem_rdata`=0xA7; then `ir_load`. Required response: `mem_req` high for 3 cycles, `mem_addr`=3, DR=0xA7, `instr`=3'b101.
- Write with AR=7, DR=0x5C: `mem_write` → `mem_we`=1 and `mem_wdata`=0x5C until `mem_ready`; `dr_load` of 0xFF during the wait is ignored.
- `pc_out` and `dr_out` together with PC=4 → `bus_out`=0x04, `error`=1, and `error` stays 1 until `RST`.
- `mem_read` while in WRITE → no state change, `error`=1; `mem_ready` in IDLE → no effect.
